multiciclo_control: RTL and testbench

MULTICICLO_CONTROL -- requirements
Module: multiciclo_control

---
 rtl/multiciclo_control.sv | 183 ++++++++++++++++++
 tb/tb_multiciclo_control.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multiciclo_control.sv
// multiciclo_control: multicycle MIPS-subset control FSM (ports: clk, rst async active-low, op_code/funct_field/Zero/mem_ready in; datapath controls, illegal, instr_done, state, instr_count out; macro MULTICICLO_JUMP_EN enables j)
module multiciclo_control #(
  parameter int CNT_W = 32,
  parameter int OP_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  op_code,
  input  logic [OP_W-1:0]  funct_field,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic             illegal,
  output logic             instr_done,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [3:0]       ALUControl,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, ADDIEX = 4'd10, ADDIWB = 4'd11
  } st_t;
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] F_ADD   = OP_W'(6'b100000);
  localparam logic [OP_W-1:0] F_SUB   = OP_W'(6'b100010);
  localparam logic [OP_W-1:0] F_AND   = OP_W'(6'b100100);
  localparam logic [OP_W-1:0] F_OR    = OP_W'(6'b100101);
  localparam logic [OP_W-1:0] F_SLT   = OP_W'(6'b101010);
  localparam logic [OP_W-1:0] F_NOR   = OP_W'(6'b100111);
  st_t st, nx;
  logic f_ok, op_ok;
  logic [3:0] f_alu;
  st_t dec_nx;
  assign state = st;
  always_comb begin
    f_ok  = 1'b1;
    f_alu = 4'b0000;
    case (funct_field)
      F_ADD:   f_alu = 4'b0010;
      F_SUB:   f_alu = 4'b0110;
      F_AND:   f_alu = 4'b0000;
      F_OR:    f_alu = 4'b0001;
      F_SLT:   f_alu = 4'b0111;
      F_NOR:   f_alu = 4'b1100;
      default: f_ok  = 1'b0;
    endcase
  end
  always_comb begin
    op_ok  = 1'b1;
    dec_nx = FETCH;
    case (op_code)
      OP_LW, OP_SW: dec_nx = MEMADR;
      OP_R:         dec_nx = EXEC;
      OP_BEQ:       dec_nx = BRANCH;
      OP_ADDI:      dec_nx = ADDIEX;
`ifdef MULTICICLO_JUMP_EN
      OP_J:         dec_nx = JUMP;
`endif
      default:      op_ok  = 1'b0;
    endcase
  end
  // Outputs are forced low for as long as rst is held, not just on the state register.
  always_comb begin
    nx         = st;
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    illegal    = 1'b0;
    instr_done = 1'b0;
    ALUSrcB    = 2'b00;
    PCSource   = 2'b00;
    ALUControl = 4'b0000;
    if (rst) begin
      case (st)
        FETCH: begin
          MemRead    = 1'b1;
          ALUSrcB    = 2'b01;
          ALUControl = 4'b0010;
          IRWrite    = mem_ready;
          PCWrite    = mem_ready;
          nx         = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          ALUSrcB    = 2'b11;
          ALUControl = 4'b0010;
          illegal    = !op_ok;
          nx         = dec_nx;
        end
        MEMADR: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          ALUControl = 4'b0010;
          nx         = (op_code == OP_SW) ? MEMWR : MEMRD;
        end
        MEMRD: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
          nx      = mem_ready ? MEMWB : MEMRD;
        end
        MEMWB: begin
          MemtoReg   = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          nx         = FETCH;
        end
        MEMWR: begin
          IorD       = 1'b1;
          MemWrite   = 1'b1;
          instr_done = mem_ready;
          nx         = mem_ready ? FETCH : MEMWR;
        end
        EXEC: begin
          ALUSrcA    = 1'b1;
          ALUControl = f_alu;
          illegal    = !f_ok;
          nx         = f_ok ? ALUWB : FETCH;
        end
        ALUWB: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          nx         = FETCH;
        end
        BRANCH: begin
          ALUSrcA    = 1'b1;
          ALUControl = 4'b0110;
          PCSource   = 2'b01;
          PCWrite    = Zero;
          instr_done = 1'b1;
          nx         = FETCH;
        end
        JUMP: begin
          PCSource   = 2'b10;
          PCWrite    = 1'b1;
          instr_done = 1'b1;
          nx         = FETCH;
        end
        ADDIEX: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          ALUControl = 4'b0010;
          nx         = ADDIWB;
        end
        ADDIWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          nx         = FETCH;
        end
        default: nx = FETCH;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st          <= FETCH;
      instr_count <= '0;
    end else begin
      st <= nx;
      if (instr_done) instr_count <= instr_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_multiciclo_control.sv
// tb_multiciclo_control: randomized instruction stream checked against a per-instruction trace model
module tb_multiciclo_control;
  localparam int CNT_W = 4;
`ifdef MULTICICLO_JUMP_EN
  localparam bit JEN = 1'b1;
`else
  localparam bit JEN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic [5:0] op_code = '0, funct_field = '0;
  logic Zero = 1'b0, mem_ready = 1'b0;
  logic PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, illegal, instr_done;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALUControl, state;
  logic [CNT_W-1:0] instr_count;
  multiciclo_control #(.CNT_W(CNT_W), .OP_W(6)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .funct_field(funct_field), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .illegal(illegal),
    .instr_done(instr_done), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUControl(ALUControl),
    .state(state), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [3:0] st;
    logic mr, rw, rd, wr, pcw, irw, ill, dn;
    logic [3:0] alu;
    logic [1:0] pcs;
  } rec_t;
  rec_t q[$];
  int nchk = 0, nerr = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic rec_t mk(input logic [3:0] s, input logic m, input logic [3:0] a);
    rec_t x;
    x = '0;
    x.st = s;
    x.mr = m;
    x.alu = a;
    return x;
  endfunction
  function automatic logic [4:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return {1'b1, 4'b0010};
      6'b100010: return {1'b1, 4'b0110};
      6'b100100: return {1'b1, 4'b0000};
      6'b100101: return {1'b1, 4'b0001};
      6'b101010: return {1'b1, 4'b0111};
      6'b100111: return {1'b1, 4'b1100};
      default:   return 5'b0;
    endcase
  endfunction
  // Expected cycle-by-cycle trace of one instruction: wf fetch stalls, wm memory stalls.
  task automatic gen(input logic [5:0] op, input logic [5:0] fn, input logic z, input int wf, input int wm);
    rec_t x, d;
    logic [4:0] fa;
    bit is_lw, is_mem;
    for (int i = 0; i < wf; i++) begin
      x = mk(0, 0, 4'b0010); x.rd = 1; q.push_back(x);
    end
    x = mk(0, 1, 4'b0010); x.rd = 1; x.pcw = 1; x.irw = 1; q.push_back(x);
    d = mk(1, 0, 4'b0010);
    is_lw = (op == 6'b100011);
    is_mem = is_lw || op == 6'b101011;
    fa = funct_alu(fn);
    if (is_mem) begin
      q.push_back(d);
      q.push_back(mk(2, 0, 4'b0010));
      for (int i = 0; i <= wm; i++) begin
        x = mk(is_lw ? 4'd3 : 4'd5, i == wm, 4'b0000);
        x.rd = is_lw; x.wr = !is_lw; x.dn = !is_lw && i == wm;
        q.push_back(x);
      end
      if (is_lw) begin
        x = mk(4, 0, 4'b0000); x.rw = 1; x.dn = 1; q.push_back(x);
      end
    end else if (op == 6'b000000) begin
      q.push_back(d);
      x = mk(6, 0, fa[3:0]); x.ill = !fa[4]; q.push_back(x);
      if (fa[4]) begin
        x = mk(7, 0, 4'b0000); x.rw = 1; x.dn = 1; q.push_back(x);
      end
    end else if (op == 6'b000100) begin
      q.push_back(d);
      x = mk(8, 0, 4'b0110); x.pcs = 2'b01; x.pcw = z; x.dn = 1; q.push_back(x);
    end else if (op == 6'b001000) begin
      q.push_back(d);
      q.push_back(mk(10, 0, 4'b0010));
      x = mk(11, 0, 4'b0000); x.rw = 1; x.dn = 1; q.push_back(x);
    end else if (op == 6'b000010 && JEN) begin
      q.push_back(d);
      x = mk(9, 0, 4'b0000); x.pcs = 2'b10; x.pcw = 1; x.dn = 1; q.push_back(x);
    end else begin
      d.ill = 1; q.push_back(d);
    end
  endtask
  task automatic run();
    rec_t x;
    while (q.size() > 0) begin
      x = q.pop_front();
      mem_ready = x.mr;
      @(negedge clk);
      check("state", 32'(state), 32'(x.st));
      check("RegWrite", 32'(RegWrite), 32'(x.rw));
      check("MemRead", 32'(MemRead), 32'(x.rd));
      check("MemWrite", 32'(MemWrite), 32'(x.wr));
      check("PCWrite", 32'(PCWrite), 32'(x.pcw));
      check("IRWrite", 32'(IRWrite), 32'(x.irw));
      check("illegal", 32'(illegal), 32'(x.ill));
      check("instr_done", 32'(instr_done), 32'(x.dn));
      check("ALUControl", 32'(ALUControl), 32'(x.alu));
      check("PCSource", 32'(PCSource), 32'(x.pcs));
      check("instr_count", 32'(instr_count), 32'(exp_cnt));
      exp_cnt += CNT_W'(x.dn);
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
  endtask
  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input int wf, input int wm);
    op_code = op;
    funct_field = fn;
    Zero = z;
    gen(op, fn, z, wf, wm);
    run();
  endtask
  task automatic do_reset();
    mem_ready = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_MemRead", 32'(MemRead), 32'd0);
    check("rst_RegWrite", 32'(RegWrite), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [5:0] ops [7];
    logic [5:0] fns [8];
    rec_t x;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b000001, 6'b110011};
    #12;
    do_reset();
    do_instr(6'b100011, 6'b0, 1'b0, 0, 0);
    do_instr(6'b101011, 6'b0, 1'b0, 1, 3);
    do_instr(6'b000100, 6'b0, 1'b1, 0, 0);
    do_instr(6'b000100, 6'b0, 1'b0, 0, 0);
    do_instr(6'b000000, 6'b101010, 1'b0, 0, 0);
    do_instr(6'b000000, 6'b000001, 1'b0, 0, 0);
    do_instr(6'b000010, 6'b0, 1'b0, 0, 0);
    for (int i = 0; i < 80; i++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      do_instr(op, fns[$urandom_range(0, 7)], 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end
    do_reset();
    for (int i = 0; i < 16; i++) do_instr(6'b001000, 6'($urandom), 1'b0, 0, 0);
    check("wrap_count", 32'(instr_count), 32'd0);
    op_code = 6'b100011;
    gen(6'b100011, 6'b0, 1'b0, 0, 3);
    while (q.size() > 0 && q[0].st != 4'd3) begin
      x = q.pop_front();
      q.push_front(x);
      begin
        rec_t one;
        one = q.pop_front();
        mem_ready = one.mr;
        @(negedge clk);
        check("pre_state", 32'(state), 32'(one.st));
        @(posedge clk);
        #1;
      end
    end
    mem_ready = 1'b0;
    @(negedge clk);
    check("memrd_state", 32'(state), 32'd3);
    check("memrd_count", 32'(instr_count), 32'd0);
    q.delete();
    do_reset();
    do_instr(6'b001000, 6'b0, 1'b0, 0, 0);
    check("post_rst_count", 32'(instr_count), 32'd1);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
